// File: rtl/axi_frame_writer.sv
// Frame writer: drains a show-ahead FIFO into a ring of frame buffers over AXI4 write,
// one INCR burst outstanding at a time, never crossing a 4 KB page.
module axi_frame_writer #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 256,
  parameter int NUM_BUF   = 3
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                START,
  input  logic                ABORT,
  input  logic [31:0]         BASE_ADRS,
  input  logic [31:0]         BUF_STRIDE,
  input  logic [31:0]         FRAME_LEN,
  input  logic                ENDIAN_MODE,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic [3:0]          DONE_BUF,
  output logic                ERR,
  input  logic [DATA_W-1:0]   FIFO_DATA,
  input  logic                FIFO_EMPTY,
  input  logic [15:0]         FIFO_LEVEL,
  output logic                FIFO_RE,
  output logic [31:0]         M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic [3:0]          M_AXI_AWCACHE,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY
);

  localparam int         BYTES     = DATA_W / 8;
  localparam int         SZ        = $clog2(BYTES);
  localparam logic [12:0] BURST_MAX = 13'(BURST_LEN);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_NEXT = 3'd5;

  logic [2:0]  state_reg;
  logic [3:0]  cur_buf_reg;
  logic [31:0] addr_reg;
  logic [31:0] rem_reg;
  logic [8:0]  beats_reg;
  logic [8:0]  beat_cnt_reg;
  logic [31:0] awaddr_reg;
  logic [7:0]  awlen_reg;
  logic        awvalid_reg;
  logic        err_reg;
  logic        abort_seen_reg;
  logic        frame_done_reg;
  logic [3:0]  done_buf_reg;

  logic [12:0] page_beats;
  logic [12:0] cap_beats;
  logic [12:0] burst_beats;
  logic        fifo_ready;
  logic [31:0] rem_after;
  logic [31:0] addr_step;
  logic [3:0]  cur_buf_next;
  logic        wvalid;
  logic        wlast;
  logic        w_hs;
  logic [DATA_W-1:0] data_swapped;

  // Beats left before the next 4 KB page; start address is word aligned so this is >= 1.
  assign page_beats   = (13'd4096 - {1'b0, addr_reg[11:0]}) >> SZ;
  assign cap_beats    = (rem_reg < 32'(BURST_LEN)) ? rem_reg[12:0] : BURST_MAX;
  assign burst_beats  = (cap_beats < page_beats) ? cap_beats : page_beats;
  assign fifo_ready   = {3'd0, burst_beats} <= FIFO_LEVEL;
  assign rem_after    = rem_reg - {23'd0, beats_reg};
  assign addr_step    = {23'd0, beats_reg} << SZ;
  assign cur_buf_next = (cur_buf_reg == 4'(NUM_BUF - 1)) ? 4'd0 : cur_buf_reg + 4'd1;

  assign wvalid = (state_reg == ST_W) & ~FIFO_EMPTY;
  assign w_hs   = wvalid & M_AXI_WREADY;
  assign wlast  = (state_reg == ST_W) && (beat_cnt_reg == beats_reg - 9'd1);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_swap
      assign data_swapped[8*gi +: 8] = FIFO_DATA[DATA_W-8-8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg      <= ST_IDLE;
      cur_buf_reg    <= 4'd0;
      addr_reg       <= 32'd0;
      rem_reg        <= 32'd0;
      beats_reg      <= 9'd0;
      beat_cnt_reg   <= 9'd0;
      awaddr_reg     <= 32'd0;
      awlen_reg      <= 8'd0;
      awvalid_reg    <= 1'b0;
      err_reg        <= 1'b0;
      abort_seen_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      done_buf_reg   <= 4'd0;
    end else begin
      frame_done_reg <= 1'b0;
      if (state_reg != ST_IDLE && ABORT)
        abort_seen_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: if (START) begin
          addr_reg       <= BASE_ADRS + {28'd0, cur_buf_reg} * BUF_STRIDE;
          rem_reg        <= FRAME_LEN >> SZ;
          err_reg        <= 1'b0;
          abort_seen_reg <= 1'b0;
          state_reg      <= ST_CALC;
        end
        ST_CALC: if (rem_reg == 32'd0) begin
          frame_done_reg <= 1'b1;
          done_buf_reg   <= cur_buf_reg;
          cur_buf_reg    <= cur_buf_next;
          state_reg      <= ST_IDLE;
        end else if (fifo_ready) begin
          beats_reg   <= burst_beats[8:0];
          awaddr_reg  <= addr_reg;
          awlen_reg   <= burst_beats[7:0] - 8'd1;
          awvalid_reg <= 1'b1;
          state_reg   <= ST_AW;
        end
        ST_AW: if (M_AXI_AWREADY) begin
          awvalid_reg  <= 1'b0;
          beat_cnt_reg <= 9'd0;
          state_reg    <= ST_W;
        end
        ST_W: if (w_hs) begin
          beat_cnt_reg <= beat_cnt_reg + 9'd1;
          if (wlast)
            state_reg <= ST_B;
        end
        ST_B: if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00)
            err_reg <= 1'b1;
          state_reg <= ST_NEXT;
        end
        ST_NEXT: begin
          addr_reg <= addr_reg + addr_step;
          rem_reg  <= rem_after;
          // An abort drops the rest of the frame, including its completion report.
          if (abort_seen_reg || ABORT) begin
            state_reg <= ST_IDLE;
          end else if (rem_after == 32'd0) begin
            frame_done_reg <= 1'b1;
            done_buf_reg   <= cur_buf_reg;
            cur_buf_reg    <= cur_buf_next;
            state_reg      <= ST_IDLE;
          end else begin
            state_reg <= ST_CALC;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign BUSY          = (state_reg != ST_IDLE);
  assign FRAME_DONE    = frame_done_reg;
  assign DONE_BUF      = done_buf_reg;
  assign ERR           = err_reg;
  assign FIFO_RE       = w_hs;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWLEN   = awlen_reg;
  assign M_AXI_AWSIZE  = 3'(SZ);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = ENDIAN_MODE ? data_swapped : FIFO_DATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = (state_reg == ST_B);

endmodule

// File: tb/tb_axi_frame_writer.sv
// Bench for axi_frame_writer: FIFO/AXI-slave model with random stalls, burst plan computed
// from page/burst limits in byte arithmetic, one scenario task per feature.
module tb_axi_frame_writer;

  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 256;
  localparam int NUM_BUF   = 3;
  localparam int BYTES     = DATA_W / 8;

  logic        ACLK, ARESETN, START, ABORT, ENDIAN_MODE;
  logic [31:0] BASE_ADRS, BUF_STRIDE, FRAME_LEN;
  logic        BUSY, FRAME_DONE, ERR, FIFO_EMPTY, FIFO_RE;
  logic [3:0]  DONE_BUF;
  logic [63:0] FIFO_DATA;
  logic [15:0] FIFO_LEVEL;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [3:0]  M_AXI_AWCACHE;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;

  axi_frame_writer #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .NUM_BUF(NUM_BUF)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .ABORT(ABORT),
    .BASE_ADRS(BASE_ADRS), .BUF_STRIDE(BUF_STRIDE), .FRAME_LEN(FRAME_LEN),
    .ENDIAN_MODE(ENDIAN_MODE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .DONE_BUF(DONE_BUF),
    .ERR(ERR), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_LEVEL(FIFO_LEVEL),
    .FIFO_RE(FIFO_RE), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  int mdl_buf = 0;
  bit stall_en = 0;
  bit fifo_stall = 0;
  int err_burst = -1;
  int b_issued, re_cnt, re_bad, b_cnt;
  bit b_pending, w_hs, b_hs;

  logic [63:0] fifo_q[$], exp_data_q[$], w_data_q[$];
  bit          w_last_q[$];
  logic [31:0] aw_addr_q[$], mdl_addr_q[$];
  logic [7:0]  aw_len_q[$], mdl_len_q[$];
  logic [3:0]  fd_q[$];

  function automatic logic [63:0] rev64(input logic [63:0] w);
    return {<<8{w}};
  endfunction

  function automatic void drive_fifo();
    FIFO_LEVEL = 16'(fifo_q.size());
    FIFO_EMPTY = (fifo_q.size() == 0) || fifo_stall;
    FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
  endfunction

  // Reference burst plan: cut the frame at BURST_LEN beats and at every 4 KB page edge.
  function automatic void model_bursts(input logic [31:0] a0, input logic [31:0] len);
    longint a, rem, page_left, chunk;
    a = a0; rem = len;
    mdl_addr_q.delete(); mdl_len_q.delete();
    while (rem > 0) begin
      page_left = 4096 - (a % 4096);
      chunk = rem;
      if (chunk > BURST_LEN * BYTES) chunk = BURST_LEN * BYTES;
      if (chunk > page_left) chunk = page_left;
      mdl_addr_q.push_back(32'(a));
      mdl_len_q.push_back(8'(chunk / BYTES - 1));
      a += chunk; rem -= chunk;
    end
  endfunction

  function automatic int data_bad(input bit endian);
    int n = 0;
    if (w_data_q.size() > exp_data_q.size()) return 9999;
    foreach (w_data_q[i])
      if (w_data_q[i] !== (endian ? rev64(exp_data_q[i]) : exp_data_q[i])) n++;
    return n;
  endfunction

  function automatic int last_bad();
    bit exp_last[$];
    int n = 0;
    foreach (mdl_len_q[b])
      for (int j = 0; j <= int'(mdl_len_q[b]); j++) exp_last.push_back(j == int'(mdl_len_q[b]));
    foreach (w_last_q[i])
      if (i >= exp_last.size() || w_last_q[i] != exp_last[i]) n++;
    return n;
  endfunction

  function automatic int aw_bad();
    int n = 0;
    if (aw_addr_q.size() != mdl_addr_q.size()) return 9999;
    foreach (aw_addr_q[i])
      if (aw_addr_q[i] !== mdl_addr_q[i] || aw_len_q[i] !== mdl_len_q[i]) n++;
    return n;
  endfunction

  // FIFO + AXI slave model: sample handshakes mid-cycle, update inputs just after the edge.
  initial begin : bfm
    forever begin
      @(negedge ACLK);
      w_hs = 0; b_hs = 0;
      if (ARESETN) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_addr_q.push_back(M_AXI_AWADDR);
          aw_len_q.push_back(M_AXI_AWLEN);
        end
        w_hs = M_AXI_WVALID && M_AXI_WREADY;
        if (w_hs) begin
          w_data_q.push_back(M_AXI_WDATA);
          w_last_q.push_back(M_AXI_WLAST);
          if (M_AXI_WLAST) b_pending = 1;
        end
        if (FIFO_RE) re_cnt++;
        if (FIFO_RE !== w_hs) re_bad++;
        b_hs = M_AXI_BVALID && M_AXI_BREADY;
        if (b_hs) b_cnt++;
        if (FRAME_DONE) fd_q.push_back(DONE_BUF);
      end
      @(posedge ACLK);
      #1;
      if (w_hs && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (b_hs) begin
        M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
      end else if (b_pending && (!stall_en || $urandom_range(0, 1) == 1)) begin
        M_AXI_BVALID = 1;
        M_AXI_BRESP  = (b_issued == err_burst) ? 2'b10 : 2'b00;
        b_issued++;
        b_pending = 0;
      end
      M_AXI_AWREADY = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_WREADY  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_stall    = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      drive_fifo();
    end
  end

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] base, stride, len, input bit endian);
    logic [63:0] w;
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
    fd_q.delete(); exp_data_q.delete();
    re_cnt = 0; re_bad = 0; b_cnt = 0; b_issued = 0;
    for (int i = 0; i < int'(len / BYTES); i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      exp_data_q.push_back(w);
    end
    drive_fifo();
    BASE_ADRS = base; BUF_STRIDE = stride; FRAME_LEN = len; ENDIAN_MODE = endian;
    START = 1;
    tick();
    START = 0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 20000; i++) begin
      if (!BUSY) begin timed_out = 0; break; end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic wait_beats(input int n, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 5000; i++) begin
      if (w_data_q.size() >= n) begin timed_out = 0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [80:0] obs;
    ARESETN = 0; START = 0; ABORT = 0; ENDIAN_MODE = 0;
    BASE_ADRS = 0; BUF_STRIDE = 0; FRAME_LEN = 0;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    drive_fifo();
    repeat (3) tick();
    obs = {BUSY, FRAME_DONE, DONE_BUF, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST,
           M_AXI_BREADY, FIFO_RE, M_AXI_AWADDR, M_AXI_AWLEN, 32'd0};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %0h required 0", obs); end
    checks++;
    if ({M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE, M_AXI_WSTRB} !== {3'd3, 2'b01, 4'b0011, 8'hFF}) begin
      errors++;
      $display("FAIL const_fields: got %0h required %0h",
               {M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE, M_AXI_WSTRB}, {3'd3, 2'b01, 4'b0011, 8'hFF});
    end
    ARESETN = 1;
    repeat (2) tick();
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_after_reset: BUSY=%0b required 0", BUSY); end
    mdl_buf = 0;
    $display("test_reset done");
  endtask

  task automatic test_two_bursts();
    bit to;
    start_frame(32'h1000_0000, 32'd0, 32'd4096, 1'b0);
    wait_idle(to);
    model_bursts(32'h1000_0000, 32'd4096);
    checks++;
    if (to) begin errors++; $display("FAIL two_bursts_timeout: BUSY stuck at 1"); end
    checks++;
    if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h1000_0000 || aw_len_q[0] !== 8'd255 ||
        aw_addr_q[1] !== 32'h1000_0800 || aw_len_q[1] !== 8'd255) begin
      errors++;
      $display("FAIL two_bursts_aw: got %0d bursts, required 255@10000000 then 255@10000800", aw_addr_q.size());
    end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] !== 4'd0) begin
      errors++; $display("FAIL two_bursts_done: got %0d pulses, required one with DONE_BUF=0", fd_q.size());
    end
    checks++;
    if (w_data_q.size() != 512 || data_bad(0) != 0 || last_bad() != 0) begin
      errors++;
      $display("FAIL two_bursts_w: beats=%0d data_bad=%0d last_bad=%0d required 512/0/0",
               w_data_q.size(), data_bad(0), last_bad());
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_two_bursts done: %0d bursts, %0d beats", aw_addr_q.size(), w_data_q.size());
  endtask

  task automatic test_4k_split();
    bit to;
    start_frame(32'h1000_0F00, 32'd0, 32'd2048, 1'b0);
    wait_idle(to);
    model_bursts(32'h1000_0F00, 32'd2048);
    checks++;
    if (to || aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h1000_0F00 || aw_len_q[0] !== 8'd31 ||
        aw_addr_q[1] !== 32'h1000_1000 || aw_len_q[1] !== 8'd223) begin
      errors++;
      $display("FAIL split_4k_aw: got %0d bursts (timeout=%0b), required 31@10000F00 then 223@10001000",
               aw_addr_q.size(), to);
    end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] !== 4'(mdl_buf) || data_bad(0) != 0 || last_bad() != 0) begin
      errors++;
      $display("FAIL split_4k_frame: pulses=%0d data_bad=%0d last_bad=%0d required 1/0/0 buf %0d",
               fd_q.size(), data_bad(0), last_bad(), mdl_buf);
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_4k_split done: %0d bursts", aw_addr_q.size());
  endtask

  task automatic test_stalls();
    bit to;
    stall_en = 1;
    start_frame(32'h1000_2000, 32'd0, 32'd72, 1'b1);
    wait_idle(to);
    stall_en = 0;
    model_bursts(32'h1000_2000, 32'd72);
    checks++;
    if (to || aw_len_q.size() != 1 || aw_len_q[0] !== 8'd8) begin
      errors++; $display("FAIL stall_aw: bursts=%0d timeout=%0b, required one AWLEN 8", aw_len_q.size(), to);
    end
    checks++;
    if (re_cnt != 9 || re_bad != 0) begin
      errors++; $display("FAIL stall_fifo_re: pulses=%0d bad=%0d required 9/0", re_cnt, re_bad);
    end
    checks++;
    if (w_last_q.size() != 9 || last_bad() != 0) begin
      errors++; $display("FAIL stall_wlast: beats=%0d last_bad=%0d required 9/0", w_last_q.size(), last_bad());
    end
    checks++;
    if (data_bad(1) != 0) begin
      errors++; $display("FAIL stall_endian_data: bad=%0d required 0", data_bad(1));
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_stalls done: %0d beats", w_data_q.size());
  endtask

  task automatic test_zero_len();
    bit to;
    start_frame(32'h1000_3000, 32'd0, 32'd0, 1'b0);
    wait_idle(to);
    checks++;
    if (to || aw_addr_q.size() != 0 || w_data_q.size() != 0) begin
      errors++; $display("FAIL zero_len_axi: bursts=%0d beats=%0d required 0/0", aw_addr_q.size(), w_data_q.size());
    end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] !== 4'(mdl_buf)) begin
      errors++; $display("FAIL zero_len_done: pulses=%0d required one with DONE_BUF=%0d", fd_q.size(), mdl_buf);
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_zero_len done");
  endtask

  task automatic test_bresp_err();
    bit to;
    err_burst = 0;
    start_frame(32'h1000_0000, 32'd0, 32'd4096, 1'b0);
    wait_idle(to);
    err_burst = -1;
    checks++;
    if (to || ERR !== 1'b1 || b_cnt != 2 || aw_addr_q.size() != 2) begin
      errors++; $display("FAIL bresp_err_set: ERR=%0b b=%0d aw=%0d required 1/2/2", ERR, b_cnt, aw_addr_q.size());
    end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] !== 4'(mdl_buf)) begin
      errors++; $display("FAIL bresp_err_done: pulses=%0d required one with DONE_BUF=%0d", fd_q.size(), mdl_buf);
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    start_frame(32'h1000_0000, 32'd0, 32'd64, 1'b0);
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL bresp_err_clear: ERR=%0b required 0", ERR); end
    wait_idle(to);
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_bresp_err done");
  endtask

  task automatic test_random();
    bit to, endian;
    logic [31:0] base, stride, len, fbase;
    bit exp_err;
    for (int k = 0; k < 6; k++) begin
      base   = 32'h4000_0000 + (32'($urandom_range(0, 32'hFFFF)) << 3);
      stride = 32'($urandom_range(0, 255)) << 12;
      len    = 32'($urandom_range(1, 400)) * BYTES;
      endian = 1'($urandom_range(0, 1));
      stall_en  = 1'($urandom_range(0, 1));
      err_burst = ($urandom_range(0, 2) == 0) ? 0 : -1;
      exp_err   = (err_burst == 0);
      fbase = base + 32'(mdl_buf) * stride;
      model_bursts(fbase, len);
      start_frame(base, stride, len, endian);
      wait_idle(to);
      stall_en = 0; err_burst = -1;
      checks++;
      if (to || aw_bad() != 0 || b_cnt != mdl_addr_q.size()) begin
        errors++;
        $display("FAIL random_aw[%0d]: timeout=%0b aw=%0d b=%0d required %0d bursts from %0h",
                 k, to, aw_addr_q.size(), b_cnt, mdl_addr_q.size(), fbase);
      end
      checks++;
      if (w_data_q.size() != int'(len / BYTES) || data_bad(endian) != 0 || last_bad() != 0 || re_bad != 0) begin
        errors++;
        $display("FAIL random_w[%0d]: beats=%0d data_bad=%0d last_bad=%0d re_bad=%0d required %0d/0/0/0",
                 k, w_data_q.size(), data_bad(endian), last_bad(), re_bad, len / BYTES);
      end
      checks++;
      if (fd_q.size() != 1 || fd_q[0] !== 4'(mdl_buf) || ERR !== exp_err) begin
        errors++;
        $display("FAIL random_done[%0d]: pulses=%0d ERR=%0b required one with buf %0d, ERR=%0b",
                 k, fd_q.size(), ERR, mdl_buf, exp_err);
      end
      $display("random frame %0d: base=%0h len=%0d bursts=%0d buf=%0d", k, fbase, len, aw_addr_q.size(), mdl_buf);
      mdl_buf = (mdl_buf + 1) % NUM_BUF;
    end
  endtask

  task automatic test_ring();
    bit to;
    logic [31:0] exp_addr;
    ARESETN = 0;
    repeat (2) tick();
    ARESETN = 1;
    tick();
    mdl_buf = 0;
    for (int k = 0; k < 4; k++) begin
      exp_addr = 32'h2000_0000 + 32'(k % 3) * 32'h0100_0000;
      start_frame(32'h2000_0000, 32'h0100_0000, 32'd256, 1'b0);
      wait_idle(to);
      checks++;
      if (to || aw_addr_q.size() != 1 || aw_addr_q[0] !== exp_addr || fd_q.size() != 1 || fd_q[0] !== 4'(k % 3)) begin
        errors++;
        $display("FAIL ring_frame[%0d]: aw=%0d addr=%0h pulses=%0d required addr %0h buf %0d",
                 k, aw_addr_q.size(), (aw_addr_q.size() != 0) ? aw_addr_q[0] : 32'd0, fd_q.size(), exp_addr, k % 3);
      end
      $display("ring frame %0d: addr=%0h", k, exp_addr);
    end
    mdl_buf = 1;
  endtask

  task automatic test_abort();
    bit to, to2;
    logic [31:0] exp_addr;
    exp_addr = 32'h1000_0000 + 32'(mdl_buf) * 32'h0100_0000;
    model_bursts(exp_addr, 32'd4096);
    start_frame(32'h1000_0000, 32'h0100_0000, 32'd4096, 1'b0);
    wait_beats(1, to);
    ABORT = 1;
    tick();
    ABORT = 0;
    wait_idle(to2);
    checks++;
    if (to || to2 || aw_addr_q.size() != 1 || aw_addr_q[0] !== exp_addr || b_cnt != 1) begin
      errors++;
      $display("FAIL abort_axi: timeout=%0b aw=%0d b=%0d required one burst at %0h and one B",
               to | to2, aw_addr_q.size(), b_cnt, exp_addr);
    end
    checks++;
    if (w_data_q.size() != 256 || last_bad() != 0 || w_last_q[255] != 1'b1) begin
      errors++; $display("FAIL abort_wlast: beats=%0d last_bad=%0d required 256 ending with WLAST", w_data_q.size(), last_bad());
    end
    checks++;
    if (fd_q.size() != 0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: pulses=%0d BUSY=%0b required 0/0", fd_q.size(), BUSY);
    end
    fifo_q.delete();
    drive_fifo();
    start_frame(32'h1000_0000, 32'h0100_0000, 32'd64, 1'b0);
    wait_idle(to);
    checks++;
    if (to || aw_addr_q.size() != 1 || aw_addr_q[0] !== exp_addr || fd_q.size() != 1 || fd_q[0] !== 4'(mdl_buf)) begin
      errors++;
      $display("FAIL abort_buf_hold: aw=%0d pulses=%0d required addr %0h and buf %0d",
               aw_addr_q.size(), fd_q.size(), exp_addr, mdl_buf);
    end
    mdl_buf = (mdl_buf + 1) % NUM_BUF;
    $display("test_abort done");
  endtask

  task automatic test_reset_midburst();
    bit to;
    logic [12:0] obs;
    start_frame(32'h3000_0000, 32'd0, 32'd4096, 1'b0);
    wait_beats(10, to);
    ARESETN = 0;
    #1;
    obs = {BUSY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, FIFO_RE, FRAME_DONE, ERR, DONE_BUF, 2'b00};
    checks++;
    if (to || obs !== '0) begin
      errors++; $display("FAIL midburst_reset: timeout=%0b outputs=%0h required 0", to, obs);
    end
    tick();
    fifo_q.delete(); b_pending = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    drive_fifo();
    ARESETN = 1;
    tick();
    start_frame(32'h3000_0000, 32'h100, 32'd64, 1'b0);
    wait_idle(to);
    checks++;
    if (to || aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h3000_0000 || fd_q.size() != 1 || fd_q[0] !== 4'd0) begin
      errors++; $display("FAIL midburst_recover: aw=%0d pulses=%0d required addr 30000000 buf 0", aw_addr_q.size(), fd_q.size());
    end
    $display("test_reset_midburst done");
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_two_bursts();
    test_4k_split();
    test_stalls();
    test_zero_len();
    test_bresp_err();
    test_random();
    test_ring();
    test_abort();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_frame_writer.md
AXI_FRAME_WRITER -- requirements
Module: axi_frame_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, AXI/FIFO data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter BURST_LEN, default 256, maximum beats per burst; power of 2, 1..256.
REQ-003 SHALL have parameter NUM_BUF, default 3, frame buffers in the ring; 1..16.
REQ-004 SHALL have port ACLK  in  1  clock; ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  in  1  request a frame write; sampled only in IDLE.
REQ-006 SHALL have port ABORT  in  1  stop after the current burst.
REQ-007 SHALL have port BASE_ADRS  in  32  byte address of buffer 0, DATA_W/8 aligned.
REQ-008 SHALL have port BUF_STRIDE  in  32  byte distance between consecutive buffers.
REQ-009 SHALL have port FRAME_LEN  in  32  frame size in bytes, multiple of DATA_W/8.
REQ-010 SHALL have port ENDIAN_MODE  in  1  1 = byte-reverse each data word.
REQ-011 SHALL have ports BUSY  out  1  not IDLE; FRAME_DONE  out  1  one-cycle pulse; DONE_BUF  out  4  index of the completed buffer; ERR  out  1  sticky error.
REQ-012 SHALL have ports FIFO_DATA  in  DATA_W  show-ahead data; FIFO_EMPTY  in  1; FIFO_LEVEL  in  16  words available; FIFO_RE  out  1.
REQ-013 SHALL have AXI write ports M_AXI_AWADDR 32, AWLEN 8, AWSIZE 3, AWBURST 2, AWCACHE 4, AWVALID/AWREADY; WDATA DATA_W, WSTRB DATA_W/8, WLAST, WVALID/WREADY; BRESP 2, BVALID/BREADY.

Function
REQ-014 SHALL drive AWSIZE=log2(DATA_W/8), AWBURST=2'b01 (INCR), AWCACHE=4'b0011, WSTRB all ones.
REQ-015 SHALL use FSM states IDLE, CALC, AW, W, B, NEXT, with one burst outstanding at a time.
REQ-016 In IDLE, START=1 SHALL latch frame address = BASE_ADRS + cur_buf*BUF_STRIDE, latch remaining beats = FRAME_LEN/(DATA_W/8), clear ERR, and go to CALC.
REQ-017 In CALC, burst beats SHALL = min(remaining, BURST_LEN, (4096 - addr[11:0])/(DATA_W/8)), so that no burst crosses a 4 KB boundary.
REQ-018 CALC SHALL advance to AW only when FIFO_LEVEL >= burst beats; AWLEN SHALL = beats-1.
REQ-019 AWVALID SHALL be registered and held until the AWREADY handshake; AW SHALL then go to W.
REQ-020 WVALID SHALL = (state==W) & ~FIFO_EMPTY; FIFO_RE SHALL = WVALID & WREADY; the beat counter SHALL advance only on a handshake.
REQ-021 WLAST SHALL be asserted on the final beat of each burst only; W SHALL go to B after the WLAST handshake.
REQ-022 BREADY SHALL be 1 in state B; on BVALID, BRESP!=2'b00 SHALL set ERR, and the FSM SHALL go to NEXT.
REQ-023 In NEXT: the address SHALL advance by beats*DATA_W/8 and remaining SHALL decrement by beats.
REQ-024 In NEXT, remaining!=0 and ABORT=0 SHALL go to CALC.
REQ-025 In NEXT, remaining==0 SHALL pulse FRAME_DONE with DONE_BUF=cur_buf, advance cur_buf modulo NUM_BUF, and go to IDLE.
REQ-026 ABORT SHALL never truncate a burst; if ABORT was seen since frame start, NEXT SHALL go to IDLE with no FRAME_DONE and no cur_buf advance.
REQ-027 FRAME_LEN=0 SHALL issue no AXI transaction, pulse FRAME_DONE one cycle after START is accepted, and advance cur_buf.
REQ-028 WDATA SHALL be FIFO_DATA, byte-reversed across the whole word when ENDIAN_MODE=1.
REQ-029 Address and remaining-count arithmetic SHALL be 32-bit unsigned; address wrap past 0xFFFF_FFFF is not supported.

Reset
REQ-030 ARESETN low SHALL force IDLE, cur_buf=0, and all outputs low (ERR=0, DONE_BUF=0), except the constant AXI fields.
REQ-031 Reset mid-burst SHALL abandon the transaction immediately; the interconnect reset is the system's responsibility.

Verification
REQ-032 DATA_W=64, BASE 0x1000_0000, FRAME_LEN 4096 -> AWLEN 255 @0x1000_0000, then AWLEN 255 @0x1000_0800; FRAME_DONE with DONE_BUF=0.
REQ-033 BASE 0x1000_0F00, FRAME_LEN 2048 -> AWLEN 31 @0x1000_0F00, then AWLEN 223 @0x1000_1000.
REQ-034 FRAME_LEN 72 with random WREADY/FIFO_EMPTY stalls -> one AWLEN 8 burst, 9 FIFO_RE pulses, WLAST on the 9th beat only.
REQ-035 NUM_BUF=3, stride 0x0100_0000, four frames -> frame base addresses +0, +0x0100_0000, +0x0200_0000, +0; DONE_BUF 0,1,2,0.
REQ-036 BRESP=2'b10 on burst 1 -> ERR=1 and the frame still completes; the next START clears ERR.
REQ-037 ABORT during the W phase of burst 1 of 2 -> burst completes with WLAST, B accepted, no second AW, BUSY=0, no FRAME_DONE.
